// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-seg scan controller.
package disp_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

  function automatic logic bcd_invalid(input logic [BCD_W-1:0] nib);
    return nib > BCD_MAX;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Scan controller bus: BCD source side in, decoder/display side out.
interface disp_scan_ctrl_if import disp_pkg::*; #(
  parameter int DIGITS = 4
);
  logic                      en;
  logic                      load;
  logic [BCD_W*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]         dp_in;
  logic [BCD_W-1:0]          bcd_out;
  logic                      bi_out;
  logic [DIGITS-1:0]         sel;
  logic                      dp_out;
  logic                      frame_done;

  modport master (
    output en, load, digits_in, dp_in,
    input  bcd_out, bi_out, sel, dp_out, frame_done
  );

  modport slave (
    input  en, load, digits_in, dp_in,
    output bcd_out, bi_out, sel, dp_out, frame_done
  );
endinterface

// File: rtl/disp_scan_ctrl_timer.sv
// Per-slot cycle counter; strobes on the last dead-time cycle and last slot cycle.
module scan_slot_timer #(
  parameter int SLOT_CYC  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic blank_end_o,
  output logic slot_end_o
);
  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign blank_end_o = (cnt_q == BLANK_LAST);
  assign slot_end_o  = (cnt_q == SLOT_LAST);

  // Held at zero while stopped so a fresh slot always starts from cycle 0.
  always_comb begin
    cnt_d = '0;
    if (run_i && !slot_end_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-seg scan controller with double-buffered digits and dead-time.
// Optional leading-zero blanking when DISP_LZB_EN is defined.
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int DIGITS    = 4,
  parameter int SLOT_CYC  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_e                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [DIGITS-1:0][BCD_W-1:0]    shd_dig_q, shd_dig_d, act_dig_q, act_dig_d;
  logic [DIGITS-1:0]               shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]               lzb;
  logic                            blank_end, slot_end, frame_wrap, copy;
  logic [BCD_W-1:0]                nib;

  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              bi_q, bi_d, dp_q, dp_d, fd_q, fd_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  scan_slot_timer #(.SLOT_CYC(SLOT_CYC), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .run_i       (bus.en && (state_q != IDLE)),
    .blank_end_o (blank_end),
    .slot_end_o  (slot_end)
  );

  assign nib        = act_dig_q[idx_q];
  assign frame_wrap = (state_q == SHOW) && bus.en && slot_end && (idx_q == LAST);

`ifdef DISP_LZB_EN
  // lead[g]: digits g..DIGITS-1 are all zero with no decimal point among them.
  logic [DIGITS:1] lead;
  assign lead[DIGITS] = 1'b1;
  assign lzb[0]       = 1'b0;
  for (genvar g = 1; g < DIGITS; g++) begin : g_lzb
    assign lead[g] = lead[g+1] && (act_dig_q[g] == '0) && !act_dp_q[g];
    assign lzb[g]  = lead[g];
  end
`else
  assign lzb = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (bus.en) state_d = BLANK;
      end
      BLANK: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (blank_end) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (slot_end) begin
          state_d = BLANK;
          idx_d   = (idx_q == LAST) ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Shadow bypass lets a load on the frame-start cycle land in the new frame.
  always_comb begin
    shd_dig_d = bus.load ? bus.digits_in : shd_dig_q;
    shd_dp_d  = bus.load ? bus.dp_in     : shd_dp_q;
    copy      = (state_q == IDLE) || frame_wrap;
    act_dig_d = copy ? shd_dig_d : act_dig_q;
    act_dp_d  = copy ? shd_dp_d  : act_dp_q;
  end

  // en=0 darkens on the very next edge, independent of the FSM lag.
  always_comb begin
    sel_d = '0;
    bi_d  = 1'b1;
    bcd_d = '0;
    dp_d  = 1'b0;
    fd_d  = 1'b0;
    if (bus.en) begin
      case (state_q)
        BLANK: bcd_d = nib;
        SHOW: begin
          sel_d = DIGITS'(1) << idx_q;
          bcd_d = nib;
          bi_d  = bcd_invalid(nib) || lzb[idx_q];
          dp_d  = act_dp_q[idx_q];
          fd_d  = frame_wrap;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
      sel_q     <= '0;
      bi_q      <= 1'b1;
      bcd_q     <= '0;
      dp_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      sel_q     <= sel_d;
      bi_q      <= bi_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.bi_out     = bi_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.dp_out     = dp_q;
  assign bus.frame_done = fd_q;
endmodule
